// File: rtl/arinc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arinc_pkg
//  Description : Shared ARINC429 definitions for the transmitter, receiver and
//                key command scheduler: SSM code, word field positions and the
//                odd-parity / word-packing helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package arinc_pkg;

    // Sign/status matrix value for "normal operation"
    localparam logic [1:0] SSM_NORMAL = 2'b11;

    // Word field positions (LSB and width of each field)
    localparam int WORD_W    = 32;
    localparam int LABEL_LSB = 0;
    localparam int LABEL_W   = 8;
    localparam int SDI_LSB   = 8;
    localparam int SDI_W     = 2;
    localparam int DATA_LSB  = 10;
    localparam int DATA_W    = 19;
    localparam int SSM_LSB   = 29;
    localparam int SSM_W     = 2;
    localparam int PAR_BIT   = 31;

    // Parity bit that makes the total number of ones in a 32-bit word odd
    function automatic logic odd_parity(input logic [30:0] bits);
        return ~(^bits);
    endfunction

    // Assemble a complete word: {parity, ssm, data, sdi, label}
    function automatic logic [31:0] pack_word(
        input logic [7:0]  label,
        input logic [1:0]  sdi,
        input logic [18:0] data,
        input logic [1:0]  ssm
    );
        logic [30:0] body;
        body = {ssm, data, sdi, label};
        return {odd_parity(body), body};
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_evt_gen.sv
`default_nettype none
// ============================================================================
//  Module      : key_evt_gen
//  Description : Per-key event generator. Synchronises one active-low key,
//                detects press edges, produces auto-repeat events while the
//                key is held and keeps a coalescing pending flag.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk        in   system clock
//    rst_n      in   asynchronous active-low reset
//    en         in   1 = new events may set the pending flag
//    key_db     in   debounced key level, 0 = pressed, asynchronous to clk
//    grant_clr  in   scheduler has taken this key's pending event
//    pending    out  an event is waiting to be sent
//    ovf        out  one-cycle pulse: event merged into an existing pending
// ============================================================================
module key_evt_gen #(
    parameter bit          REPEAT_EN  = 1'b1,
    parameter int unsigned REPEAT_DLY = 25_000_000,
    parameter int unsigned REPEAT_PER = 5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic key_db,
    input  logic grant_clr,
    output logic pending,
    output logic ovf
);

    localparam int              HOLD_W      = $clog2(REPEAT_DLY + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX    = HOLD_W'(REPEAT_DLY);
    // Reloading with DLY-PER makes the next repeat come PER cycles later
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DLY - REPEAT_PER);

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              prev_q,  prev_d;
    logic [HOLD_W-1:0] hold_q,  hold_d;
    logic              pending_q, pending_d;
    logic              ovf_q,   ovf_d;

    logic              press;
    logic              rpt;
    logic              evt;
    logic [HOLD_W-1:0] hold_inc;

    always_comb begin
        sync1_d  = key_db;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        press    = prev_q & ~sync2_q;
        hold_inc = hold_q + HOLD_W'(1);
        hold_d   = hold_q;
        rpt      = 1'b0;

        if (!en || sync2_q || press) begin
            // Disabled, released, or a fresh press: hold time restarts at 0
            hold_d = '0;
        end else if (REPEAT_EN) begin
            if (hold_inc == HOLD_MAX) begin
                rpt    = 1'b1;
                hold_d = HOLD_RELOAD;
            end else begin
                hold_d = hold_inc;
            end
        end

        evt = en & (press | rpt);

        // A set in the same cycle as the grant clear wins and is not an
        // overflow: the new event still gets its own word.
        pending_d = evt | (pending_q & ~grant_clr);
        ovf_d     = evt & pending_q & ~grant_clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            hold_q    <= '0;
            pending_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            hold_q    <= hold_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    assign pending = pending_q;
    assign ovf     = ovf_q;

endmodule
`default_nettype wire

// File: rtl/key_cmd_sched.sv
`default_nettype none
// ============================================================================
//  Module      : key_cmd_sched
//  Description : Converts four debounced front-panel keys into ARINC429
//                command words and schedules them round-robin onto the
//                shared transmitter through a valid/ready handshake.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk       in   system clock
//    rst_n     in   asynchronous active-low reset
//    en        in   1 = accept new key events
//    key_db    in   [3:0] debounced keys, 0 = pressed, asynchronous
//    tx_valid  out  tx_word is valid
//    tx_ready  in   transmitter accepts the word
//    tx_word   out  [31:0] ARINC429 word
//    tx_key    out  [1:0] index of the key being sent
//    ovf       out  one-cycle pulse when an event hits an already-pending key
// ============================================================================
module key_cmd_sched
    import arinc_pkg::*;
#(
    parameter logic [7:0]  LABEL0     = 8'o201,
    parameter logic [7:0]  LABEL1     = 8'o202,
    parameter logic [7:0]  LABEL2     = 8'o203,
    parameter logic [7:0]  LABEL3     = 8'o204,
    parameter logic [1:0]  SDI        = 2'b00,
    parameter bit          REPEAT_EN  = 1'b1,
    parameter int unsigned REPEAT_DLY = 25_000_000,
    parameter int unsigned REPEAT_PER = 5_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [3:0]  key_db,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] tx_word,
    output logic [1:0]  tx_key,
    output logic        ovf
);

    localparam int NKEYS = 4;
    localparam logic [NKEYS-1:0][7:0] LABELS = {LABEL3, LABEL2, LABEL1, LABEL0};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                       state_q, state_d;
    logic [1:0]                   rr_q, rr_d;
    logic [NKEYS-1:0][DATA_W-1:0] cnt_q, cnt_d;
    logic                         tx_valid_q, tx_valid_d;
    logic [31:0]                  tx_word_q, tx_word_d;
    logic [1:0]                   tx_key_q, tx_key_d;

    logic [NKEYS-1:0]             pending;
    logic [NKEYS-1:0]             ovf_vec;
    logic [NKEYS-1:0]             grant_clr;

    logic                         gnt_found;
    logic [1:0]                   gnt_idx;
    logic [1:0]                   cand;
    logic [DATA_W-1:0]            cnt_next;

    // ------------------------------------------------------------------
    // One event generator per key
    // ------------------------------------------------------------------
    generate
        for (genvar k = 0; k < NKEYS; k++) begin : g_key
            key_evt_gen #(
                .REPEAT_EN  (REPEAT_EN),
                .REPEAT_DLY (REPEAT_DLY),
                .REPEAT_PER (REPEAT_PER)
            ) u_evt (
                .clk       (clk),
                .rst_n     (rst_n),
                .en        (en),
                .key_db    (key_db[k]),
                .grant_clr (grant_clr[k]),
                .pending   (pending[k]),
                .ovf       (ovf_vec[k])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin search: first pending key at or after rr_q, wrapping
    // ------------------------------------------------------------------
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = rr_q;
        cand      = rr_q;
        for (int i = 0; i < NKEYS; i++) begin
            cand = rr_q + 2'(i);
            if (!gnt_found && pending[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
        // The 19-bit counter wraps naturally from 0x7FFFF to 0
        cnt_next = cnt_q[gnt_idx] + DATA_W'(1);
    end

    // ------------------------------------------------------------------
    // Scheduler FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        tx_valid_d = tx_valid_q;
        tx_word_d  = tx_word_q;
        tx_key_d   = tx_key_q;
        grant_clr  = '0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_found) begin
                    grant_clr[gnt_idx] = 1'b1;
                    cnt_d[gnt_idx]     = cnt_next;
                    tx_word_d          = pack_word(LABELS[gnt_idx], SDI, cnt_next, SSM_NORMAL);
                    tx_key_d           = gnt_idx;
                    tx_valid_d         = 1'b1;
                    rr_d               = gnt_idx + 2'd1;
                    state_d            = ST_SEND;
                end
            end
            ST_SEND: begin
                // Word is held stable until the transmitter takes it; en
                // has no influence here so a started transfer completes.
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_q       <= 2'd0;
            cnt_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_word_q  <= '0;
            tx_key_q   <= 2'd0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            tx_valid_q <= tx_valid_d;
            tx_word_q  <= tx_word_d;
            tx_key_q   <= tx_key_d;
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_word  = tx_word_q;
    assign tx_key   = tx_key_q;
    // Each generator's ovf is already a registered single-cycle pulse
    assign ovf      = |ovf_vec;

endmodule
`default_nettype wire

// File: tb/tb_key_cmd_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_cmd_sched
//  Description : Scoreboard testbench for key_cmd_sched. Stimulus pushes the
//                expected words; a monitor pops and compares on every cycle
//                the DUT presents tx_valid.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_key_cmd_sched;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        en     = 1'b1;
    logic [3:0]  key_db = 4'hF;
    logic        tx_ready = 1'b1;
    logic        tx_valid;
    logic [31:0] tx_word;
    logic [1:0]  tx_key;
    logic        ovf;

    // Second instance with auto-repeat disabled
    logic [3:0]  key_db_nr   = 4'hF;
    logic        tx_ready_nr = 1'b1;
    logic        tx_valid_nr;
    logic [31:0] tx_word_nr;
    logic [1:0]  tx_key_nr;
    logic        ovf_nr;

    always #5 clk = ~clk;

    key_cmd_sched #(
        .REPEAT_EN  (1'b1),
        .REPEAT_DLY (20),
        .REPEAT_PER (8)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .key_db   (key_db),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_word  (tx_word),
        .tx_key   (tx_key),
        .ovf      (ovf)
    );

    key_cmd_sched #(
        .REPEAT_EN  (1'b0)
    ) u_dut_nr (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (1'b1),
        .key_db   (key_db_nr),
        .tx_valid (tx_valid_nr),
        .tx_ready (tx_ready_nr),
        .tx_word  (tx_word_nr),
        .tx_key   (tx_key_nr),
        .ovf      (ovf_nr)
    );

    typedef struct packed {
        logic [1:0]  key;
        logic [31:0] word;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec    = 0;
    int          n_fail   = 0;
    int          ovf_cnt  = 0;
    int          nr_words = 0;
    bit          gap_chk  = 1'b0;
    logic [18:0] exp_cnt [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference word: {odd parity, SSM=11, count, SDI=00, label}
    function automatic logic [31:0] exp_word(input int k, input logic [18:0] c);
        logic [7:0]  lbl;
        logic [30:0] b;
        case (k)
            0:       lbl = 8'o201;
            1:       lbl = 8'o202;
            2:       lbl = 8'o203;
            default: lbl = 8'o204;
        endcase
        b = {2'b11, c, 2'b00, lbl};
        return {~(^b), b};
    endfunction

    task automatic expect_key(input int k);
        exp_t e;
        exp_cnt[k] = exp_cnt[k] + 19'd1;
        e.key  = 2'(k);
        e.word = exp_word(k, exp_cnt[k]);
        sb_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input int lim);
        int c = 0;
        while (!tx_valid && c < lim) begin
            tick(1);
            c++;
        end
        check(name, {31'd0, tx_valid}, 32'd1);
    endtask

    task automatic wait_empty(input string name, input int lim);
        int c = 0;
        while (sb_q.size() != 0 && c < lim) begin
            tick(1);
            c++;
        end
        check(name, sb_q.size(), 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Monitor: compare every presented word against the scoreboard head
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (gap_chk) begin
            check("idle_gap_after_accept", {31'd0, tx_valid}, 32'd0);
            gap_chk = 1'b0;
        end
        if (tx_valid) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_word: got key %0d word %h, expected no word", tx_key, tx_word);
            end else begin
                check("tx_word", tx_word, sb_q[0].word);
                check("tx_key", {30'd0, tx_key}, {30'd0, sb_q[0].key});
                if (tx_ready) begin
                    void'(sb_q.pop_front());
                    gap_chk = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (ovf) ovf_cnt++;
        if (tx_valid_nr && tx_ready_nr) begin
            nr_words++;
            check("norep_word", tx_word_nr, 32'h6000_0481);
            check("norep_key", {30'd0, tx_key_nr}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 4; k++) exp_cnt[k] = '0;

        // ---------------- reset values ----------------
        tick(3);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_word", tx_word, 32'd0);
        check("rst_tx_key", {30'd0, tx_key}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        rst_n = 1'b1;
        tick(3);

        // ---------------- no-repeat instance: 100-cycle hold ----------------
        key_db_nr[0] = 1'b0;
        tick(100);
        key_db_nr[0] = 1'b1;
        tick(10);
        check("norep_word_count", nr_words, 32'd1);

        // ---------------- single press, latency ----------------
        // Key driven just after edge 0: pending at edge 3, valid at edge 4
        key_db[0] = 1'b0;
        expect_key(0);
        tick(3);
        check("latency_edge3_valid", {31'd0, tx_valid}, 32'd0);
        tick(1);
        check("latency_edge4_valid", {31'd0, tx_valid}, 32'd1);
        tick(6);
        key_db[0] = 1'b1;
        wait_empty("single_press_drain", 50);
        tick(5);

        // ---------------- backpressure on key 3 (leaves RR at 0) ----------------
        tx_ready  = 1'b0;
        key_db[3] = 1'b0;
        expect_key(3);
        tick(5);
        key_db[3] = 1'b1;
        wait_valid("bp_valid_timeout", 20);
        tick(10);
        tx_ready = 1'b1;
        wait_empty("bp_drain", 20);
        tick(3);

        // ---------------- simultaneous press, twice ----------------
        for (int r = 0; r < 2; r++) begin
            key_db = 4'h0;
            for (int k = 0; k < 4; k++) expect_key(k);
            tick(5);
            key_db = 4'hF;
            wait_empty("simul_drain", 60);
            tick(5);
        end

        // ---------------- en=0 blocks events ----------------
        en        = 1'b0;
        key_db[1] = 1'b0;
        tick(8);
        key_db[1] = 1'b1;
        tick(6);
        en = 1'b1;
        tick(10);

        // ---------------- auto-repeat on key 2 ----------------
        // Low for 40 cycles: press edge then repeats at hold 20, 28, 36;
        // release reaches the synchroniser before hold 44.
        ovf_cnt   = 0;
        key_db[2] = 1'b0;
        repeat (4) expect_key(2);
        tick(40);
        key_db[2] = 1'b1;
        wait_empty("repeat_drain", 100);
        tick(30);
        check("repeat_ovf_none", ovf_cnt, 32'd0);

        // ---------------- reset during SEND ----------------
        tx_ready  = 1'b0;
        key_db[2] = 1'b0;
        expect_key(2);
        tick(4);
        key_db[2] = 1'b1;
        wait_valid("rst_mid_valid_timeout", 20);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid_drop", {31'd0, tx_valid}, 32'd0);
        sb_q.delete();
        for (int k = 0; k < 4; k++) exp_cnt[k] = '0;
        tick(3);
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        tick(20);

        // ---------------- overflow coalescing on key 1 ----------------
        tx_ready  = 1'b0;
        ovf_cnt   = 0;
        key_db[0] = 1'b0;
        expect_key(0);
        tick(4);
        key_db[0] = 1'b1;
        wait_valid("ovf_block_valid_timeout", 20);
        key_db[1] = 1'b0;
        expect_key(1);
        tick(4);
        key_db[1] = 1'b1;
        tick(6);
        key_db[1] = 1'b0;
        tick(4);
        key_db[1] = 1'b1;
        tick(6);
        check("ovf_pulse_count", ovf_cnt, 32'd1);
        tx_ready = 1'b1;
        wait_empty("ovf_drain", 40);
        tick(5);

        // ---------------- counter wrap on key 3 ----------------
        force u_dut.cnt_q = {4{19'h7FFFF}};
        tick(1);
        release u_dut.cnt_q;
        tick(1);
        // label 0x84, data 0, SSM 11 -> four ones, parity bit set
        sb_q.push_back('{key: 2'd3, word: 32'hE000_0084});
        key_db[3] = 1'b0;
        tick(4);
        key_db[3] = 1'b1;
        wait_empty("wrap_drain", 30);
        tick(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
